dct_block_scheduler: RTL

DCT_BLOCK_SCHEDULER -- requirements
Module: dct_block_scheduler

---
 rtl/dct_block_scheduler_pkg.sv | 22 ++
 rtl/dct_sched_watchdog.sv | 44 ++++
 rtl/dct_block_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dct_block_scheduler_pkg.sv
// rtl/dct_block_scheduler_pkg.sv - shared types and defaults for the DCT block scheduler
// Purpose : scheduler state encoding, parameter defaults and block geometry.
// Ports   : none (package).
package dct_block_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESET_DCT = 2'd1,
        ST_RUN       = 2'd2
    } sched_state_e;

    localparam int NUM_SLOTS_DEF      = 4;
    localparam int RESET_HOLD_DEF     = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // Bytes per source slot; the engine's 6-bit fetch address spans one slot.
    localparam int BLOCK_SIZE = 64;

    // Output ping-pong banks.
    localparam int NUM_BANKS = 2;

endpackage

// File: rtl/dct_sched_watchdog.sv
// rtl/dct_sched_watchdog.sv - RUN-state timeout counter for the DCT block scheduler
// Purpose : counts consecutive cycles spent in RUN and flags expiry on the
//           TIMEOUT_CYCLES-th such cycle. Counter returns to zero whenever
//           the scheduler is outside RUN, so every RUN entry starts fresh.
// Ports   : clock      - rising-edge clock
//           nreset     - asynchronous active-low reset
//           run_i      - scheduler is in RUN this cycle
//           expired_o  - this is the last permitted RUN cycle
module dct_sched_watchdog
    import dct_block_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic nreset,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dct_block_scheduler.sv
// rtl/dct_block_scheduler.sv - slot/bank scheduler driving a DCT engine
// Purpose : tracks source slots written by upstream, runs the DCT engine
//           once per pending slot (reset pulse, then run until finished),
//           and ping-pongs the two output banks with downstream.
//           Optional RUN watchdog enabled by defining DCT_SCHED_TIMEOUT_EN.
// Ports   : clock, nreset                       - clock, async active-low reset
//           in_block_valid, in_slot, in_full,
//           overflow                            - upstream slot handshake
//           dct_nreset, dct_finished,
//           src_slot, dst_bank                  - DCT engine control/addressing
//           out_bank, out_block_valid,
//           out_block_ack                       - downstream bank handshake
//           busy, blocks_done, timeout_err      - status
module dct_block_scheduler
    import dct_block_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
    parameter int RESET_HOLD     = RESET_HOLD_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         in_block_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] in_slot,
    output logic                         in_full,
    output logic                         overflow,
    output logic                         dct_nreset,
    input  logic                         dct_finished,
    output logic [$clog2(NUM_SLOTS)-1:0] src_slot,
    output logic                         dst_bank,
    output logic                         out_bank,
    output logic                         out_block_valid,
    input  logic                         out_block_ack,
    output logic                         busy,
    output logic [15:0]                  blocks_done,
    output logic                         timeout_err
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);

    if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0 ||
        RESET_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dct_block_scheduler: illegal parameter value");
    end

    sched_state_e  state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    banks_q, banks_d;
    logic [SW-1:0] in_slot_q;
    logic [SW-1:0] src_slot_q;
    logic          dst_bank_q;
    logic          out_bank_q;
    logic          overflow_q;
    logic          dct_nreset_q;
    logic [15:0]   blocks_done_q;
    logic [HW-1:0] hold_q;

    logic accept;
    logic retire;
    logic drop;
    logic ack_take;
    logic wd_expired;

    // Upstream writes are refused outright when every slot is pending; a
    // retire in the same cycle does not make room until the next cycle.
    assign accept   = in_block_valid && (cnt_q != CW'(NUM_SLOTS));
    assign retire   = (state_q == ST_RUN) && dct_finished;
    // A finishing engine beats a simultaneous watchdog expiry.
    assign drop     = (state_q == ST_RUN) && !dct_finished && wd_expired;
    assign ack_take = out_block_ack && (banks_q != 2'd0);

`ifdef DCT_SCHED_TIMEOUT_EN
    logic timeout_err_q;

    dct_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .nreset   (nreset),
        .run_i    (state_q == ST_RUN),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            timeout_err_q <= 1'b0;
        end else if (drop) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        cnt_d   = cnt_q + CW'(accept) - CW'(retire || drop);
        banks_d = banks_q + 2'(retire) - 2'(ack_take);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            banks_q       <= '0;
            in_slot_q     <= '0;
            src_slot_q    <= '0;
            dst_bank_q    <= 1'b0;
            out_bank_q    <= 1'b0;
            overflow_q    <= 1'b0;
            dct_nreset_q  <= 1'b0;
            blocks_done_q <= '0;
            hold_q        <= '0;
        end else begin
            cnt_q   <= cnt_d;
            banks_q <= banks_d;
            if (accept) begin
                in_slot_q <= in_slot_q + SW'(1);
            end
            if (in_block_valid && !accept) begin
                overflow_q <= 1'b1;
            end
            if (ack_take) begin
                out_bank_q <= ~out_bank_q;
            end

            case (state_q)
                ST_IDLE: begin
                    dct_nreset_q <= 1'b0;
                    if (cnt_q != '0 && banks_q < 2'(NUM_BANKS)) begin
                        state_q <= ST_RESET_DCT;
                        hold_q  <= '0;
                    end
                end
                ST_RESET_DCT: begin
                    if (hold_q == HW'(RESET_HOLD - 1)) begin
                        state_q      <= ST_RUN;
                        dct_nreset_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                ST_RUN: begin
                    if (retire || drop) begin
                        state_q      <= ST_IDLE;
                        dct_nreset_q <= 1'b0;
                        src_slot_q   <= src_slot_q + SW'(1);
                    end
                    if (retire) begin
                        dst_bank_q    <= ~dst_bank_q;
                        blocks_done_q <= blocks_done_q + 16'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    dct_nreset_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_slot         = in_slot_q;
    assign in_full         = (cnt_q == CW'(NUM_SLOTS));
    assign overflow        = overflow_q;
    assign dct_nreset      = dct_nreset_q;
    assign src_slot        = src_slot_q;
    assign dst_bank        = dst_bank_q;
    assign out_bank        = out_bank_q;
    assign out_block_valid = (banks_q != 2'd0);
    assign busy            = (state_q != ST_IDLE);
    assign blocks_done     = blocks_done_q;

endmodule
